axis_lrelu_cfg_router: RTL and testbench
========================================

Name: axis_lrelu_cfg_router

Overview:
- Parametrised successor of the LReLU-engine front-end sequencer.
- Splits one AXI-Stream from the conv core into two paths: per-iteration config beats to the LReLU engine config port, and data beats to the downstream width converter.
- Config length is computed from a kernel-width field in tuser (any kernel width, not only 1x1/3x3). FILL wait is parametrised.
- Instantiated between conv core and the DW bank + lrelu engine.

Parameters:
- DATA_WIDTH, 1024, s_axis_tdata width.
- TUSER_WIDTH, 8, s_axis_tuser width.
- KW_MAX, 7, largest kernel width supported.
- I_KW, 0, LSB index of kernel-width field in tuser; field width is $clog2(KW_MAX+1).
- BEATS_BASE, 3, config beats independent of kernel width (D + A).
- BEATS_PER_KW, 2, config beats per kernel column (B).
- FILL_KW_MAX, 1, kernel widths <= this enter FILL after config.
- FILL_DELAY, 2, clken-qualified cycles spent in FILL (>=1).
- I_REUSE, 7, tuser bit requesting config reuse (used only with the optional feature).

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_axis_tvalid, in, 1, upstream valid.
- s_axis_tready, out, 1, upstream ready.
- s_axis_tdata, in, DATA_WIDTH, upstream data.
- s_axis_tuser, in, TUSER_WIDTH, upstream user.
- s_axis_tlast, in, 1, last beat of iteration data.
- dw_s_valid, out, 1, valid to DW converter.
- dw_s_ready, in, 1, ready from DW converter.
- dw_m_last_hs, in, 1, tlast handshake leaving the DW converter (last && valid && clken).
- engine_clken, in, 1, engine/slice clock enable.
- cfg_valid, out, 1, config beat valid to engine.
- cfg_last, out, 1, high on final config beat.
- cfg_kw, out, $clog2(KW_MAX+1), latched kernel width.
- config_resetn, out, 1, one-cycle active-low clear of engine config buffers.
- state_dbg, out, 3, current state.

Behaviour:
- State encoding: PASS=0, BLOCK=1, RESET=2, WRITE_1=3, WRITE_2=4, FILL=5. Reset state is WRITE_1.
- Reset values: count_cfg=0, count_fill=0, cfg_kw=0.
- tdata and tuser fan out combinationally to both paths. All valid/ready outputs are combinational from state.
- hs = s_axis_tvalid && s_axis_tready.
- kw_eff: the tuser field, with 0 mapped to 1 and values > KW_MAX saturated to KW_MAX.
- WRITE_1:
  - cfg_valid = s_axis_tvalid; s_axis_tready = engine_clken; dw_s_valid = 0.
  - On hs: latch cfg_kw = kw_eff; count_cfg = BEATS_BASE + BEATS_PER_KW*kw_eff - 2; go to WRITE_2.
- WRITE_2:
  - Same path as WRITE_1.
  - On hs: count_cfg decrements.
  - cfg_last = (count_cfg==0).
  - hs with count_cfg==0 goes to FILL if cfg_kw <= FILL_KW_MAX, else to PASS.
- FILL:
  - s_axis_tready = 0. count_fill increments when engine_clken is high.
  - When count_fill==FILL_DELAY-1 and engine_clken: go to PASS and clear count_fill.
- PASS:
  - dw_s_valid = s_axis_tvalid; s_axis_tready = dw_s_ready.
  - On hs with s_axis_tlast: go to BLOCK.
  - If dw_m_last_hs is also high in the same cycle: go directly to RESET.
- BLOCK:
  - s_axis_tready = 0. On dw_m_last_hs: go to RESET.
- RESET:
  - config_resetn = 0; s_axis_tready = 0.
  - When engine_clken: go to WRITE_1. Otherwise hold, keeping config_resetn low.
- config_resetn is 1 in all other states.
- Boundaries:
  - A tlast arriving during WRITE_x is treated as config, with no effect on state.
  - A minimum-length config (BEATS_BASE + BEATS_PER_KW = 2 beats) is handled because WRITE_1 loads count 0.
  - aresetn mid-iteration returns immediately to WRITE_1 with counters cleared.
  - engine_clken low freezes the RESET and FILL progress; WRITE handshakes cannot occur while it is low.

Optional Feature:
- Macro: LRELU_CFG_REUSE_EN.
- Defined:
  - In WRITE_1, if s_axis_tuser[I_REUSE] is high, the beat is data, not config.
  - dw_s_valid = s_axis_tvalid, s_axis_tready = dw_s_ready, cfg_valid = 0.
  - On hs go to PASS, or to BLOCK if tlast is set. cfg_kw is unchanged.
  - This skips config reload when consecutive iterations share parameters.
- Undefined: the I_REUSE bit is ignored and every iteration requires config.

Test Plan:
- kw=3, 9 config beats, then 4 data beats with tlast on beat 4, dw_m_last_hs 3 cycles later:
  - cfg_valid on 9 beats, cfg_last on beat 9.
  - state goes 3→4→0→1→2→3.
  - config_resetn low exactly 1 cycle.
- kw=1, FILL_DELAY=2, engine_clken toggling 1,0,1:
  - 5 config beats, then FILL for 3 cycles, then PASS.
  - s_axis_tready=0 throughout FILL.
- kw field=0:
  - cfg_kw=1, 5 config beats, then FILL.
- kw field=9 with KW_MAX=7:
  - cfg_kw=7, 17 config beats.
- In PASS, tlast hs and dw_m_last_hs in the same cycle:
  - next state is RESET (2), skipping BLOCK.
- aresetn pulsed low during WRITE_2 with count_cfg=4:
  - state=3, count_cfg=0, config_resetn=1.
- With LRELU_CFG_REUSE_EN defined, I_REUSE set on the first beat:
  - beat routed to dw_s_valid, cfg_valid stays 0, cfg_kw keeps its old value.
  - With the macro undefined, the same stimulus is consumed as config.

Source files
------------

// File: rtl/axis_lrelu_cfg_router.sv
// Splits one AXI-Stream into config beats for the LReLU engine and data beats for the DW converter.
// Latency: zero cycles, because every valid/ready is combinational from state. Config length is latched on the first beat.
// Backpressure: WRITE_x stalls on engine_clken, PASS on dw_s_ready. FILL, BLOCK and RESET hold tready low.
//
// Ports:
//   aclk, aresetn                        clock and asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tuser/tlast upstream stream from the conv core
//   dw_s_valid, dw_s_ready               data path handshake towards the DW converter
//   dw_m_last_hs                         tlast handshake observed leaving the DW converter
//   engine_clken                         engine/slice clock enable
//   cfg_valid, cfg_last, cfg_kw          config path towards the LReLU engine
//   config_resetn                        active-low clear of the engine config buffers (RESET state)
//   state_dbg                            current FSM state
// Optional feature macro: LRELU_CFG_REUSE_EN. When it is defined, the tuser[I_REUSE] bit on the first
// beat turns that beat into data and skips the config reload.
// tdata and tuser are wired to both consumers in the parent, so this block only steers the handshakes.
module axis_lrelu_cfg_router #(
  parameter int DATA_WIDTH   = 1024,
  parameter int TUSER_WIDTH  = 8,
  parameter int KW_MAX       = 7,
  parameter int I_KW         = 0,
  parameter int BEATS_BASE   = 3,
  parameter int BEATS_PER_KW = 2,
  parameter int FILL_KW_MAX  = 1,
  parameter int FILL_DELAY   = 2,
  parameter int I_REUSE      = 7
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]          s_axis_tuser,
  input  logic                            s_axis_tlast,
  output logic                            dw_s_valid,
  input  logic                            dw_s_ready,
  input  logic                            dw_m_last_hs,
  input  logic                            engine_clken,
  output logic                            cfg_valid,
  output logic                            cfg_last,
  output logic [$clog2(KW_MAX+1)-1:0]     cfg_kw,
  output logic                            config_resetn,
  output logic [2:0]                      state_dbg
);

  localparam int KW_W    = $clog2(KW_MAX + 1);
  localparam int CFG_MAX = BEATS_BASE + BEATS_PER_KW * KW_MAX - 2;
  localparam int CNT_W   = (CFG_MAX > 1) ? $clog2(CFG_MAX + 1) : 1;
  localparam int FILL_W  = (FILL_DELAY > 1) ? $clog2(FILL_DELAY) : 1;
  localparam logic [KW_W-1:0] KW_MAX_V = KW_W'(KW_MAX);

  typedef enum logic [2:0] {
    S_PASS    = 3'd0,
    S_BLOCK   = 3'd1,
    S_RESET   = 3'd2,
    S_WRITE_1 = 3'd3,
    S_WRITE_2 = 3'd4,
    S_FILL    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_count_cfg;
  logic [FILL_W-1:0] r_count_fill;
  logic [KW_W-1:0]   r_cfg_kw;

  logic [KW_W-1:0]   w_kw_field;
  logic [KW_W-1:0]   w_kw_eff;
  logic [CNT_W-1:0]  w_cfg_len_m2;
  logic              w_reuse;
  logic              w_rdy;
  logic              w_hs;
  logic              w_fill_done;
  logic              w_unused;

  // Kernel width 0 is treated as 1x1. Field values above KW_MAX saturate.
  assign w_kw_field = s_axis_tuser[I_KW +: KW_W];
  assign w_kw_eff   = (w_kw_field == '0)       ? KW_W'(1)  :
                      (w_kw_field > KW_MAX_V)  ? KW_MAX_V  : w_kw_field;

  // The count is total beats minus 2. WRITE_1 consumes one beat, and WRITE_2 runs down to 0 inclusive.
  assign w_cfg_len_m2 = CNT_W'(BEATS_BASE) + CNT_W'(BEATS_PER_KW) * CNT_W'(w_kw_eff) - CNT_W'(2);

  assign w_fill_done = engine_clken && (r_count_fill == FILL_W'(FILL_DELAY - 1));

`ifdef LRELU_CFG_REUSE_EN
  assign w_reuse = (r_state == S_WRITE_1) && s_axis_tuser[I_REUSE];
`else
  assign w_reuse = 1'b0;
`endif

  // The payload is steered outside this block, so it only feeds this sink here.
  assign w_unused = ^{s_axis_tdata, s_axis_tuser, s_axis_tuser[I_REUSE]};

  always_comb begin
    w_state_nxt   = r_state;
    w_rdy         = 1'b0;
    w_hs          = 1'b0;
    dw_s_valid    = 1'b0;
    cfg_valid     = 1'b0;
    cfg_last      = 1'b0;
    config_resetn = 1'b1;

    case (r_state)
      S_WRITE_1: begin
        if (w_reuse) begin
          dw_s_valid = s_axis_tvalid;
          w_rdy      = dw_s_ready;
        end else begin
          cfg_valid  = s_axis_tvalid;
          w_rdy      = engine_clken;
        end
      end
      S_WRITE_2: begin
        cfg_valid = s_axis_tvalid;
        w_rdy     = engine_clken;
        cfg_last  = (r_count_cfg == '0);
      end
      S_PASS: begin
        dw_s_valid = s_axis_tvalid;
        w_rdy      = dw_s_ready;
      end
      S_RESET: config_resetn = 1'b0;
      default: ;
    endcase

    w_hs = s_axis_tvalid && w_rdy;

    case (r_state)
      S_WRITE_1: begin
        if (w_hs) begin
          if (w_reuse) w_state_nxt = s_axis_tlast ? S_BLOCK : S_PASS;
          else         w_state_nxt = S_WRITE_2;
        end
      end
      S_WRITE_2: begin
        if (w_hs && (r_count_cfg == '0))
          w_state_nxt = (int'(r_cfg_kw) <= FILL_KW_MAX) ? S_FILL : S_PASS;
      end
      S_FILL: begin
        if (w_fill_done) w_state_nxt = S_PASS;
      end
      S_PASS: begin
        // If the converter drains its own last beat in the same cycle, there is nothing to wait for in BLOCK.
        if (w_hs && s_axis_tlast) w_state_nxt = dw_m_last_hs ? S_RESET : S_BLOCK;
      end
      S_BLOCK: begin
        if (dw_m_last_hs) w_state_nxt = S_RESET;
      end
      S_RESET: begin
        if (engine_clken) w_state_nxt = S_WRITE_1;
      end
      default: w_state_nxt = S_WRITE_1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_WRITE_1;
      r_count_cfg  <= '0;
      r_count_fill <= '0;
      r_cfg_kw     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_WRITE_1) && w_hs && !w_reuse) begin
        r_cfg_kw    <= w_kw_eff;
        r_count_cfg <= w_cfg_len_m2;
      end else if ((r_state == S_WRITE_2) && w_hs && (r_count_cfg != '0)) begin
        r_count_cfg <= r_count_cfg - CNT_W'(1);
      end
      if ((r_state == S_FILL) && engine_clken)
        r_count_fill <= w_fill_done ? '0 : r_count_fill + FILL_W'(1);
    end
  end

  assign s_axis_tready = w_rdy;
  assign cfg_kw        = r_cfg_kw;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_axis_lrelu_cfg_router.sv
module tb_axis_lrelu_cfg_router;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [1023:0] s_axis_tdata;
  logic [7:0]    s_axis_tuser;
  logic          s_axis_tlast;
  logic          dw_s_valid;
  logic          dw_s_ready;
  logic          dw_m_last_hs;
  logic          engine_clken;
  logic          cfg_valid;
  logic          cfg_last;
  logic [2:0]    cfg_kw;
  logic          config_resetn;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axis_lrelu_cfg_router dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .dw_s_valid    (dw_s_valid),
    .dw_s_ready    (dw_s_ready),
    .dw_m_last_hs  (dw_m_last_hs),
    .engine_clken  (engine_clken),
    .cfg_valid     (cfg_valid),
    .cfg_last      (cfg_last),
    .cfg_kw        (cfg_kw),
    .config_resetn (config_resetn),
    .state_dbg     (state_dbg)
  );

  // exp = {tready, dw_s_valid, cfg_valid, cfg_last, config_resetn, state[2:0], cfg_kw[2:0]}
  typedef struct {
    logic       tvalid;
    logic [7:0] tuser;
    logic       tlast;
    logic       dwr;
    logic       mlh;
    logic       ck;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] u, input logic l, input logic dr,
                     input logic mh, input logic ck, input logic rdy, input logic dv,
                     input logic cv, input logic cl, input logic crn, input logic [2:0] st,
                     input logic [2:0] kw);
    vec_t t;
    t.tvalid = v; t.tuser = u; t.tlast = l; t.dwr = dr; t.mlh = mh; t.ck = ck;
    t.exp = {rdy, dv, cv, cl, crn, st, kw};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  initial begin
    logic [10:0] act;

    // ---- kw=3: 9 config beats (tlast mid-config ignored), data with a backpressure cycle, BLOCK, RESET
    add(1, 8'd3, 0, 1, 0, 1,  1, 0, 1, 0, 1, 3'd3, 3'd0);
    for (int k = 7; k >= 0; k--) add(1, 8'd3, (k == 4), 1, 0, 1,  1, 0, 1, (k == 0), 1, 3'd4, 3'd3);
    add(1, 8'd0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 3'd0, 3'd3);
    add(1, 8'd0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 3'd0, 3'd3);
    add(1, 8'd0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 3'd0, 3'd3);
    add(1, 8'd0, 0, 1, 0, 1,  1, 1, 0, 0, 1, 3'd0, 3'd3);
    add(1, 8'd0, 1, 1, 0, 1,  1, 1, 0, 0, 1, 3'd0, 3'd3);
    add(1, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd1, 3'd3);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd1, 3'd3);
    add(0, 8'd0, 0, 1, 1, 1,  0, 0, 0, 0, 1, 3'd1, 3'd3);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3'd2, 3'd3);
    // ---- kw field 0 -> cfg_kw 1, 5 beats, FILL (2 cycles), PASS, BLOCK, RESET
    add(1, 8'd0, 0, 1, 0, 1,  1, 0, 1, 0, 1, 3'd3, 3'd3);
    for (int k = 3; k >= 0; k--) add(1, 8'd0, 0, 1, 0, 1,  1, 0, 1, (k == 0), 1, 3'd4, 3'd1);
    add(1, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd5, 3'd1);
    add(1, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd5, 3'd1);
    add(1, 8'd0, 1, 1, 0, 1,  1, 1, 0, 0, 1, 3'd0, 3'd1);
    add(0, 8'd0, 0, 1, 1, 1,  0, 0, 0, 0, 1, 3'd1, 3'd1);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3'd2, 3'd1);
    // ---- kw=1: WRITE_1 stalled by clken, FILL with clken 1,0,1, tlast+last_hs -> RESET held by clken
    add(1, 8'd1, 0, 1, 0, 0,  0, 0, 1, 0, 1, 3'd3, 3'd1);
    add(1, 8'd1, 0, 1, 0, 1,  1, 0, 1, 0, 1, 3'd3, 3'd1);
    for (int k = 3; k >= 0; k--) add(1, 8'd1, 0, 1, 0, 1,  1, 0, 1, (k == 0), 1, 3'd4, 3'd1);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd5, 3'd1);
    add(1, 8'd0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 3'd5, 3'd1);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 1, 3'd5, 3'd1);
    add(1, 8'd0, 1, 1, 1, 1,  1, 1, 0, 0, 1, 3'd0, 3'd1);
    add(0, 8'd0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'd2, 3'd1);
    add(0, 8'd0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'd2, 3'd1);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3'd2, 3'd1);
    // ---- kw=7: 17 config beats straight to PASS
    add(1, 8'd7, 0, 1, 0, 1,  1, 0, 1, 0, 1, 3'd3, 3'd1);
    for (int k = 15; k >= 0; k--) add(1, 8'd7, 0, 1, 0, 1,  1, 0, 1, (k == 0), 1, 3'd4, 3'd7);
    add(1, 8'd0, 1, 1, 1, 1,  1, 1, 0, 0, 1, 3'd0, 3'd7);
    add(0, 8'd0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3'd2, 3'd7);
    // ---- reuse bit on first beat (kw field 2)
`ifdef LRELU_CFG_REUSE_EN
    add(1, 8'h82, 0, 1, 0, 1,  1, 1, 0, 0, 1, 3'd3, 3'd7);
    add(0, 8'h00, 0, 1, 0, 1,  1, 0, 0, 0, 1, 3'd0, 3'd7);
`else
    add(1, 8'h82, 0, 1, 0, 1,  1, 0, 1, 0, 1, 3'd3, 3'd7);
    add(0, 8'h00, 0, 1, 0, 1,  1, 0, 0, 0, 1, 3'd4, 3'd2);
`endif

    // ---- reset state
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; dw_s_ready = 1'b1; dw_m_last_hs = 1'b0; engine_clken = 1'b1;
    #12;
    check("rst_state", int'(state_dbg), 3);
    check("rst_cfg_kw", int'(cfg_kw), 0);
    check("rst_config_resetn", int'(config_resetn), 1);
    check("rst_count_cfg", int'(dut.r_count_cfg), 0);
    check("rst_count_fill", int'(dut.r_count_fill), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // ---- table
    for (int i = 0; i < vecs.size(); i++) begin
      s_axis_tvalid = vecs[i].tvalid;
      s_axis_tuser  = vecs[i].tuser;
      s_axis_tlast  = vecs[i].tlast;
      s_axis_tdata  = {32{i}};
      dw_s_ready    = vecs[i].dwr;
      dw_m_last_hs  = vecs[i].mlh;
      engine_clken  = vecs[i].ck;
      #1;
      act = {s_axis_tready, dw_s_valid, cfg_valid, cfg_last, config_resetn, state_dbg, cfg_kw};
      n_checks++;
      if (act !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %b expected %b (rdy,dwv,cfgv,cfgl,crn,st,kw)", i, act, vecs[i].exp);
      end
      @(posedge aclk); #1;
    end

    // ---- asynchronous reset in the middle of WRITE_2 with count_cfg=4
    s_axis_tvalid = 1'b0; dw_m_last_hs = 1'b0; engine_clken = 1'b1; dw_s_ready = 1'b1;
    aresetn = 1'b0; #2; aresetn = 1'b1;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b1; s_axis_tuser = 8'd2; s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    check("mid_state_before", int'(state_dbg), 4);
    check("mid_count_before", int'(dut.r_count_cfg), 4);
    #2; aresetn = 1'b0; #1;
    check("arst_state", int'(state_dbg), 3);
    check("arst_count_cfg", int'(dut.r_count_cfg), 0);
    check("arst_config_resetn", int'(config_resetn), 1);
    check("arst_cfg_kw", int'(cfg_kw), 0);
    #2; aresetn = 1'b1;
    @(posedge aclk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
